ntt_host_ctrl: RTL and testbench



---
 rtl/ntt_host_ctrl_pkg.sv | 49 ++++
 rtl/ntt_host_ctrl_cnt.sv | 36 +++
 rtl/ntt_host_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_ntt_host_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_host_ctrl_pkg.sv
// ntt_host_ctrl_pkg
// Shared types and helpers for the NTT host controller:
//   state_t  - controller FSM states
//   OP_*     - host command op codes (cmd_op)
//   err_t    - sticky error codes reported on err
//   w_count  - number of twiddle words per ring/PE configuration
// No ports (package).

`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif
`ifndef RING_DEPTH
`define RING_DEPTH 10
`endif
`ifndef PE_DEPTH
`define PE_DEPTH 3
`endif

package ntt_host_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_LOAD,
        S_GAPW,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    localparam logic OP_LOADW = 1'b0;
    localparam logic OP_RUN   = 1'b1;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNDERRUN = 2'd1,
        ERR_NO_TW    = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_t;

    // Width of the shared down-counter; wide enough for any TIMEOUT.
    localparam int unsigned CNT_W = 32;

    function automatic int unsigned w_count(input int unsigned ring_depth,
                                            input int unsigned pe_depth);
        return (((32'd1 << (ring_depth - pe_depth)) - 32'd1) + pe_depth) << pe_depth;
    endfunction

endpackage

// File: rtl/ntt_host_ctrl_cnt.sv
// ntt_host_ctrl_cnt
// Loadable down-counter shared by word, gap and timeout counting.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  synchronous, active-low; clears count
//   load     in  load load_val (has priority over dec)
//   dec      in  decrement by one, saturating at zero
//   load_val in  WIDTH value to load
//   count    out WIDTH current count
//   zero     out count == 0

module ntt_host_ctrl_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ntt_host_ctrl.sv
// ntt_host_ctrl
// Host-side sequencer for an NTT core: loads twiddles (LOADW) or runs a
// transform (RUN), streaming input words into the core, pulsing start,
// waiting for done with a timeout and forwarding the result stream.
// Ports:
//   clk, reset            clock (rising edge), synchronous active-low reset
//   cmd_valid/ready/op    host command handshake; op 0 = LOADW, 1 = RUN
//   in_valid/ready/data   input word stream (gapless once started)
//   out_valid/data/last   result stream, no backpressure
//   ntt_load_w            one-cycle strobe starting a twiddle load
//   ntt_load_data         one-cycle strobe starting a data load
//   ntt_start             one-cycle strobe starting the transform
//   ntt_din               registered word to the core
//   ntt_done, ntt_dout    completion flag and result data from the core
//   busy                  controller not idle
//   err                   sticky error code, cleared by next accepted command

`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif
`ifndef RING_DEPTH
`define RING_DEPTH 10
`endif
`ifndef PE_DEPTH
`define PE_DEPTH 3
`endif

module ntt_host_ctrl
    import ntt_host_ctrl_pkg::*;
#(
    parameter int unsigned DATA_SIZE_ARB = `DATA_SIZE_ARB,
    parameter int unsigned RING_DEPTH    = `RING_DEPTH,
    parameter int unsigned PE_DEPTH      = `PE_DEPTH,
    parameter int unsigned GAP           = 5,
    parameter int unsigned TIMEOUT       = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_op,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_SIZE_ARB-1:0] in_data,
    output logic                     out_valid,
    output logic [DATA_SIZE_ARB-1:0] out_data,
    output logic                     out_last,
    output logic                     ntt_load_w,
    output logic                     ntt_load_data,
    output logic                     ntt_start,
    output logic [DATA_SIZE_ARB-1:0] ntt_din,
    input  logic                     ntt_done,
    input  logic [DATA_SIZE_ARB-1:0] ntt_dout,
    output logic                     busy,
    output logic [1:0]               err
);

    localparam int unsigned RING_SIZE = 32'd1 << RING_DEPTH;
    localparam int unsigned W_COUNT   = w_count(RING_DEPTH, PE_DEPTH);
    localparam int unsigned N_LOADW   = 2 * W_COUNT + 2;
    localparam int unsigned N_RUN     = RING_SIZE;

    // Counter reload values are "cycles - 1" so the zero flag marks the last cycle.
    localparam logic [CNT_W-1:0] LD_LOADW   = CNT_W'(N_LOADW - 1);
    localparam logic [CNT_W-1:0] LD_RUN     = CNT_W'(N_RUN - 1);
    localparam logic [CNT_W-1:0] LD_GAP     = CNT_W'((GAP == 0) ? 0 : GAP - 1);
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_DRAIN   = CNT_W'(RING_SIZE - 1);

    state_t state, state_next;
    logic   op, op_next;
    err_t   err_q, err_next;
    logic   w_loaded, w_loaded_next;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val, cnt_count;

    ntt_host_ctrl_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            op       <= OP_LOADW;
            err_q    <= ERR_NONE;
            w_loaded <= 1'b0;
            ntt_din  <= '0;
        end else begin
            state    <= state_next;
            op       <= op_next;
            err_q    <= err_next;
            w_loaded <= w_loaded_next;
            if (in_ready && in_valid) begin
                ntt_din <= in_data;
            end
        end
    end

    always_comb begin
        state_next    = state;
        op_next       = op;
        err_next      = err_q;
        w_loaded_next = w_loaded;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        cnt_val       = '0;
        cmd_ready     = 1'b0;
        in_ready      = 1'b0;
        ntt_load_w    = 1'b0;
        ntt_load_data = 1'b0;
        ntt_start     = 1'b0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        out_data      = '0;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    err_next = ERR_NONE;
                    op_next  = cmd_op;
                    if ((cmd_op == OP_RUN) && !w_loaded) begin
                        // Rejected RUN stays in IDLE: no strobe, no in_ready.
                        err_next = ERR_NO_TW;
                    end else begin
                        state_next = S_PULSE;
                        cnt_load   = 1'b1;
                        cnt_val    = (cmd_op == OP_RUN) ? LD_RUN : LD_LOADW;
                    end
                end
            end

            S_PULSE, S_LOAD: begin
                in_ready = 1'b1;
                if (state == S_PULSE) begin
                    ntt_load_w    = (op == OP_LOADW);
                    ntt_load_data = (op == OP_RUN);
                end
                if (!in_valid) begin
                    err_next   = ERR_UNDERRUN;
                    state_next = S_IDLE;
                end else if (cnt_zero) begin
                    if (GAP != 0) begin
                        cnt_load   = 1'b1;
                        cnt_val    = LD_GAP;
                        state_next = S_GAPW;
                    end else if (op == OP_RUN) begin
                        state_next = S_START;
                    end else begin
                        w_loaded_next = 1'b1;
                        state_next    = S_IDLE;
                    end
                end else begin
                    cnt_dec    = 1'b1;
                    state_next = S_LOAD;
                end
            end

            S_GAPW: begin
                if (cnt_zero) begin
                    if (op == OP_RUN) begin
                        state_next = S_START;
                    end else begin
                        w_loaded_next = 1'b1;
                        state_next    = S_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            S_START: begin
                ntt_start  = 1'b1;
                cnt_load   = 1'b1;
                cnt_val    = LD_TIMEOUT;
                state_next = S_WAIT;
            end

            S_WAIT: begin
                // done wins over timeout when both land on the same cycle
                if (ntt_done) begin
                    cnt_load   = 1'b1;
                    cnt_val    = LD_DRAIN;
                    state_next = S_DRAIN;
                end else if (cnt_zero) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = S_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = ntt_dout;
                out_last  = cnt_zero;
                if (cnt_zero) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_ntt_host_ctrl.sv
// tb_ntt_host_ctrl
// Directed bench for ntt_host_ctrl with RING_DEPTH=4, PE_DEPTH=1, GAP=5,
// TIMEOUT=100. Expected ntt_din words and result beats are queued as they
// are driven and checked by a negedge monitor; control flags are checked
// inline from the stimulus sequence.

module tb_ntt_host_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned NO_DROP = 32'hFFFF;
    localparam logic [DW-1:0] GOLD [16] = '{
        16'h3A71, 16'h0F2C, 16'hB9E4, 16'h5507, 16'hC1D8, 16'h2B66, 16'h9F10, 16'h7E3D,
        16'h14A9, 16'hE852, 16'h6CC1, 16'h0371, 16'hD49E, 16'h8B05, 16'h47FA, 16'hFFFE
    };

    logic          clk = 1'b0;
    logic          reset, cmd_valid, cmd_op, in_valid, ntt_done;
    logic [DW-1:0] in_data, ntt_dout;
    logic          cmd_ready, in_ready, out_valid, out_last;
    logic          ntt_load_w, ntt_load_data, ntt_start, busy;
    logic [DW-1:0] out_data, ntt_din;
    logic [1:0]    err;

    int checks   = 0;
    int failures = 0;
    int n_load_w = 0, n_load_data = 0, n_start = 0, n_beats = 0;
    bit din_pending = 1'b0;

    logic [DW-1:0] din_q [$];
    logic [DW:0]   out_q [$];

    always #5 clk = ~clk;

    ntt_host_ctrl #(
        .DATA_SIZE_ARB (DW),
        .RING_DEPTH    (4),
        .PE_DEPTH      (1),
        .GAP           (5),
        .TIMEOUT       (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .ntt_load_w    (ntt_load_w),
        .ntt_load_data (ntt_load_data),
        .ntt_start     (ntt_start),
        .ntt_din       (ntt_din),
        .ntt_done      (ntt_done),
        .ntt_dout      (ntt_dout),
        .busy          (busy),
        .err           (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: ntt_din one cycle after each handshake, result beats.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (din_pending) begin
            chk("din_queue_nonempty", 32'(din_q.size() != 0), 1);
            if (din_q.size() != 0) chk("ntt_din", ntt_din, din_q.pop_front());
        end
        din_pending = in_valid && in_ready;
        if (out_valid) begin
            n_beats++;
            chk("beat_queue_nonempty", 32'(out_q.size() != 0), 1);
            if (out_q.size() != 0) begin
                e = out_q.pop_front();
                chk("out_data", out_data, e[DW-1:0]);
                chk("out_last", out_last, e[DW]);
            end
        end
        n_load_w    += int'(ntt_load_w);
        n_load_data += int'(ntt_load_data);
        n_start     += int'(ntt_start);
        if (ntt_load_w || ntt_load_data || ntt_start)
            chk("strobe_onehot", 32'(ntt_load_w) + 32'(ntt_load_data) + 32'(ntt_start), 1);
    end

    task automatic issue(input logic op);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called in the PULSE cycle; drops in_valid at word drop_at.
    task automatic feed(input int unsigned n, input int unsigned drop_at, input logic [DW-1:0] base);
        for (int unsigned i = 0; i < n; i++) begin
            if (i == drop_at) begin
                in_valid = 1'b0;
                tick();
                return;
            end
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            din_q.push_back(base + DW'(i));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int unsigned n = 0;
        while (ntt_start !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("start_seen", ntt_start, 1);
    endtask

    // Model NTT: done 40 cycles after start, then GOLD on dout. A nonzero
    // reset_beat pulls reset low during that beat and returns the cycle after.
    task automatic run_ntt(input int unsigned reset_beat);
        wait_start();
        repeat (40) tick();
        ntt_done = 1'b1;
        ntt_dout = 16'hDEAD;
        tick();
        ntt_done = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            ntt_dout = GOLD[i];
            out_q.push_back({(i == 15), GOLD[i]});
            if (i + 1 == reset_beat) begin
                reset = 1'b0;
                tick();
                return;
            end
            tick();
        end
        ntt_dout = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; in_valid = 1'b0;
        in_data = '0; ntt_done = 1'b0; ntt_dout = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ntt_din", ntt_din, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b1;
        tick();

        // RUN without twiddles
        issue(1'b1);
        chk("notw_err", err, 2);
        chk("notw_busy", busy, 0);
        chk("notw_in_ready", in_ready, 0);
        chk("notw_strobes", 32'(n_load_data + n_start + n_load_w), 0);

        // done outside WAIT
        ntt_done = 1'b1;
        repeat (3) tick();
        ntt_done = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_beats", 32'(n_beats), 0);

        // LOADW, 34 gapless words
        issue(1'b0);
        chk("loadw_pulse", ntt_load_w, 1);
        chk("loadw_in_ready", in_ready, 1);
        chk("loadw_err_cleared", err, 0);
        feed(34, NO_DROP, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            chk("loadw_gap_busy", busy, 1);
            tick();
        end
        chk("loadw_done_busy", busy, 0);
        chk("loadw_err", err, 0);
        chk("loadw_din_held", ntt_din, 16'h0021);
        chk("loadw_pulses", 32'(n_load_w), 1);

        // RUN with model NTT
        issue(1'b1);
        chk("run_pulse", ntt_load_data, 1);
        feed(16, NO_DROP, 16'h0080);
        b = n_beats;
        run_ntt(0);
        chk("run_beats", 32'(n_beats - b), 16);
        chk("run_idle", busy, 0);
        chk("run_err", err, 0);

        // RUN with underrun at word 7
        b = n_start;
        issue(1'b1);
        feed(16, 7, 16'h0040);
        chk("under_err", err, 1);
        chk("under_busy", busy, 0);
        chk("under_in_ready", in_ready, 0);
        repeat (25) tick();
        chk("under_no_start", 32'(n_start - b), 0);

        // RUN with done never raised
        issue(1'b1);
        chk("to_err_cleared", err, 0);
        feed(16, NO_DROP, 16'h00C0);
        wait_start();
        repeat (100) tick();
        chk("to_pre_busy", busy, 1);
        chk("to_pre_err", err, 0);
        tick();
        chk("to_err", err, 3);
        chk("to_busy", busy, 0);

        // Reset during drain beat 5
        issue(1'b1);
        feed(16, NO_DROP, 16'h0010);
        run_ntt(5);
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_last", out_last, 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_busy", busy, 0);
        chk("mr_err", err, 0);
        chk("mr_in_ready", in_ready, 0);
        chk("mr_strobes", 32'(ntt_load_w) + 32'(ntt_load_data) + 32'(ntt_start), 0);
        chk("mr_ntt_din", ntt_din, 0);
        reset = 1'b1;
        ntt_dout = '0;
        chk("mr_cmd_ready", cmd_ready, 1);
        tick();
        issue(1'b1);
        chk("mr_notw_err", err, 2);
        chk("mr_notw_busy", busy, 0);
        chk("mr_notw_in_ready", in_ready, 0);

        repeat (3) tick();
        chk("din_queue_drained", 32'(din_q.size()), 0);
        chk("beat_queue_drained", 32'(out_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
